// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM state and bus-owner encodings for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CORE) ? OWN_DBG : OWN_CORE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational two-way round-robin pick between core and debug.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic   c_elig,
  input  logic   d_elig,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = c_elig | d_elig;
    grant_owner = OWN_CORE;
    // On a tie the requester that did not own the bus last goes next.
    if (c_elig && d_elig) begin
      grant_owner = other_owner(last_owner);
    end else if (d_elig) begin
      grant_owner = OWN_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between the core FSM and a debug port
//               with round-robin arbitration, debug halt and response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  input  logic          d_halt,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state, state_nxt;
  owner_t        owner, owner_nxt;
  owner_t        last_owner, last_owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          m_en_nxt, m_we_nxt, c_ack_nxt, d_ack_nxt, err_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic [DW-1:0] m_wdata_nxt, c_rdata_nxt, d_rdata_nxt;
  logic          grant_valid;
  owner_t        grant_owner;

  arb_rr_pick u_pick (
    .c_elig      (c_req && !d_halt),
    .d_elig      (d_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Uses the registered ack, so the stall drops in the ack cycle itself.
  assign c_stall = c_req && !c_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_CORE;
      last_owner <= OWN_DBG;
      cnt        <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      m_en       <= m_en_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      c_ack      <= c_ack_nxt;
      d_ack      <= d_ack_nxt;
      c_rdata    <= c_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    m_en_nxt       = 1'b0;
    m_we_nxt       = m_we;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    c_ack_nxt      = 1'b0;
    d_ack_nxt      = 1'b0;
    c_rdata_nxt    = c_rdata;
    d_rdata_nxt    = d_rdata;
    err_nxt        = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_nxt = grant_owner;
          m_en_nxt  = 1'b1;
          state_nxt = ARB_ISSUE;
          if (grant_owner == OWN_CORE) begin
            m_we_nxt    = c_we;
            m_addr_nxt  = c_addr;
            m_wdata_nxt = c_wdata;
          end else begin
            m_we_nxt    = d_we;
            m_addr_nxt  = d_addr;
            m_wdata_nxt = d_wdata;
          end
        end
      end
      ARB_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A response on the final counted cycle still beats the timeout.
        if (m_rvalid || cnt == TO_LAST) begin
          state_nxt = ARB_ACK;
          err_nxt   = !m_rvalid;
          if (owner == OWN_CORE) begin
            c_ack_nxt   = 1'b1;
            c_rdata_nxt = m_rvalid ? m_rdata : '0;
          end else begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = m_rvalid ? m_rdata : '0;
          end
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ARB_ACK: begin
        last_owner_nxt = owner;
        state_nxt      = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we, d_halt, m_rvalid;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata, m_rdata;
  logic          c_ack, c_stall, d_ack, m_en, m_we, err;
  logic [DW-1:0] c_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  int compared   = 0;
  int mismatched = 0;
  int n;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(7)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_halt(d_halt),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_men();
    int k = 0;
    while (m_en !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk1("men_seen", m_en, 1'b1);
  endtask

  // Called in the m_en cycle; returns in the ack cycle.
  task automatic respond(input logic [DW-1:0] data);
    step();
    m_rvalid = 1'b1;
    m_rdata  = data;
    step();
    m_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    d_halt = 0; m_rvalid = 0; m_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk1("rst_m_en", m_en, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk1("rst_c_ack", c_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_c_stall", c_stall, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk32("rst_m_wdata", m_wdata, 32'h0);
    chk32("rst_c_rdata", c_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);

    // Core read at minimum latency
    c_req = 1; c_we = 0; c_addr = 32'h100;
    #1;
    chk1("t2_stall_c0", c_stall, 1'b1);
    chk1("t2_men_c0", m_en, 1'b0);
    step();
    chk1("t2_men_c1", m_en, 1'b1);
    chk32("t2_maddr", m_addr, 32'h100);
    chk1("t2_mwe", m_we, 1'b0);
    chk1("t2_stall_c1", c_stall, 1'b1);
    step();
    m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    chk1("t2_men_c2", m_en, 1'b0);
    chk1("t2_stall_c2", c_stall, 1'b1);
    step();
    m_rvalid = 0;
    chk1("t2_cack_c3", c_ack, 1'b1);
    chk32("t2_crdata", c_rdata, 32'hDEADBEEF);
    chk1("t2_stall_c3", c_stall, 1'b0);
    chk1("t2_err", err, 1'b0);
    chk1("t2_dack", d_ack, 1'b0);
    c_req = 0;
    step();
    chk1("t2_cack_c4", c_ack, 1'b0);

    // Simultaneous requests after a fresh reset alternate core, debug, core
    rst = 1; step(); step(); rst = 0;
    c_req = 1; c_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    wait_men();
    chk32("t3_g1_addr", m_addr, 32'h10);
    respond(32'h1111);
    chk1("t3_g1_cack", c_ack, 1'b1);
    chk1("t3_g1_dack", d_ack, 1'b0);
    chk32("t3_g1_rdata", c_rdata, 32'h1111);
    wait_men();
    chk32("t3_g2_addr", m_addr, 32'h20);
    respond(32'h2222);
    chk1("t3_g2_dack", d_ack, 1'b1);
    chk1("t3_g2_cack", c_ack, 1'b0);
    chk32("t3_g2_rdata", d_rdata, 32'h2222);
    wait_men();
    chk32("t3_g3_addr", m_addr, 32'h10);
    respond(32'h3333);
    chk1("t3_g3_cack", c_ack, 1'b1);
    c_req = 0; d_req = 0;

    // Debug halt locks out the core
    d_halt = 1;
    c_req = 1; c_we = 0; c_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
    wait_men();
    chk32("t4_dbg_addr", m_addr, 32'h40);
    chk1("t4_dbg_we", m_we, 1'b1);
    chk32("t4_dbg_wdata", m_wdata, 32'h55);
    chk1("t4_stall", c_stall, 1'b1);
    respond(32'h0);
    chk1("t4_dack", d_ack, 1'b1);
    chk1("t4_cack", c_ack, 1'b0);
    chk1("t4_stall_ack", c_stall, 1'b1);
    d_req = 0; d_we = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("t4_halt_men", m_en, 1'b0);
      chk1("t4_halt_stall", c_stall, 1'b1);
    end
    d_halt = 0;
    wait_men();
    chk32("t4_core_addr", m_addr, 32'h300);
    chk1("t4_core_we", m_we, 1'b0);
    respond(32'h300D);
    chk1("t4_core_ack", c_ack, 1'b1);
    chk32("t4_core_rdata", c_rdata, 32'h300D);
    c_req = 0;

    // No response: timeout after TIMEOUT wait cycles
    c_req = 1; c_addr = 32'h500;
    wait_men();
    n = 0;
    do begin
      step();
      n++;
    end while (c_ack !== 1'b1 && n < 200);
    chk32("t5_latency", n, TIMEOUT + 1);
    chk1("t5_err", err, 1'b1);
    chk32("t5_rdata_zero", c_rdata, 32'h0);
    c_req = 0;
    step();
    chk1("t5_err_pulse", err, 1'b0);

    // Response on the final counted cycle beats the timeout
    c_req = 1; c_addr = 32'h504;
    wait_men();
    repeat (TIMEOUT) step();
    chk1("t5b_no_early_ack", c_ack, 1'b0);
    m_rvalid = 1; m_rdata = 32'hA5A5A5A5;
    step();
    m_rvalid = 0;
    chk1("t5b_ack", c_ack, 1'b1);
    chk1("t5b_no_err", err, 1'b0);
    chk32("t5b_rdata", c_rdata, 32'hA5A5A5A5);
    c_req = 0;

    // Reset while waiting; late response ignored, core wins re-arbitration
    c_req = 1; c_addr = 32'h600; d_req = 1; d_we = 0; d_addr = 32'h700;
    wait_men();
    chk32("t6_pre_owner_dbg", m_addr, 32'h700);
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk1("t6_rst_men", m_en, 1'b0);
    chk1("t6_rst_dack", d_ack, 1'b0);
    chk32("t6_rst_drdata", d_rdata, 32'h0);
    chk32("t6_rst_maddr", m_addr, 32'h0);
    step();
    m_rvalid = 1; m_rdata = 32'hBAD;
    chk1("t6_regrant_men", m_en, 1'b1);
    chk32("t6_regrant_core", m_addr, 32'h600);
    step();
    m_rvalid = 0;
    chk1("t6_late_cack", c_ack, 1'b0);
    chk1("t6_late_dack", d_ack, 1'b0);
    m_rvalid = 1; m_rdata = 32'h600D;
    step();
    m_rvalid = 0;
    chk1("t6_cack", c_ack, 1'b1);
    chk32("t6_crdata", c_rdata, 32'h600D);
    chk32("t6_drdata", d_rdata, 32'h0);
    c_req = 0; d_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
